// File: rtl/control_unit.sv
// Multi-cycle LEGv8 control FSM: fetch, decode, execute, memory and
// conditional-branch sequencing with registered datapath strobes.
module control_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] IR,
   input  logic [3:0]  status,
   output logic        add_tri_sel,
   output logic [1:0]  data_tri_sel,
   output logic        w_reg,
   output logic        C0,
   output logic        mem_cs,
   output logic        mem_write_en,
   output logic        IR_load,
   output logic        status_load,
   output logic        B_Sel,
   output logic [31:0] k,
   output logic [4:0]  FS,
   output logic [1:0]  size,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic [4:0]  DA,
   output logic [1:0]  PC_sel,
   output logic        halt
);

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, CBR, HALT
   } state_t;

   typedef enum logic [3:0] {
      C_BAD, C_ADD, C_SUB, C_AND, C_ORR,
      C_ADDI, C_SUBI, C_ANDI, C_ORRI,
      C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ
   } cls_t;

   typedef struct packed {
      logic        add_tri_sel;
      logic [1:0]  data_tri_sel;
      logic        w_reg;
      logic        c0;
      logic        mem_cs;
      logic        mem_write_en;
      logic        ir_load;
      logic        status_load;
      logic        b_sel;
      logic [31:0] k;
      logic [4:0]  fs;
      logic [4:0]  sa;
      logic [4:0]  sb;
      logic [4:0]  da;
      logic [1:0]  pc_sel;
      logic        halt;
   } ctl_t;

   localparam ctl_t IDLE = '0;
   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b01100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;

   state_t state, nxt;
   cls_t   cls, dec_cls, c;
   ctl_t   ctl_q, ctl_d;
   logic   run;
   logic   take;
   logic   unused_flags;

   logic [4:0]  rd, rn, rm;
   logic [31:0] imm_k, dt_k, br_k, cb_k;

   assign rd    = IR[4:0];
   assign rn    = IR[9:5];
   assign rm    = IR[20:16];
   assign imm_k = {20'b0, IR[21:10]};
   assign dt_k  = {{23{IR[20]}}, IR[20:12]};
   assign br_k  = {{4{IR[25]}}, IR[25:0], 2'b00};
   assign cb_k  = {{11{IR[23]}}, IR[23:5], 2'b00};
   assign unused_flags = ^status[3:1];

   always_comb begin
      dec_cls = C_BAD;
      unique case (1'b1)
         IR[31:21] == 11'b10001011000: dec_cls = C_ADD;
         IR[31:21] == 11'b11001011000: dec_cls = C_SUB;
         IR[31:21] == 11'b10001010000: dec_cls = C_AND;
         IR[31:21] == 11'b10101010000: dec_cls = C_ORR;
         IR[31:22] == 10'b1001000100:  dec_cls = C_ADDI;
         IR[31:22] == 10'b1101000100:  dec_cls = C_SUBI;
         IR[31:22] == 10'b1001001000:  dec_cls = C_ANDI;
         IR[31:22] == 10'b1011001000:  dec_cls = C_ORRI;
         IR[31:21] == 11'b11111000010: dec_cls = C_LDUR;
         IR[31:21] == 11'b11111000000: dec_cls = C_STUR;
         IR[31:26] == 6'b000101:       dec_cls = C_B;
         IR[31:24] == 8'b10110100:     dec_cls = C_CBZ;
         IR[31:24] == 8'b10110101:     dec_cls = C_CBNZ;
         default:                      dec_cls = C_BAD;
      endcase
   end

   // Outputs are registered, so they are decoded for the state being entered.
   always_comb begin
      nxt   = state;
      ctl_d = IDLE;
      c     = (state == DECODE) ? dec_cls : cls;
      if (!run) begin
         nxt = FETCH;
      end else begin
         case (state)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = (dec_cls == C_BAD) ? HALT : EXEC;
            EXEC: begin
               if (cls inside {C_LDUR, C_STUR})
                  nxt = MEM;
               else if (cls inside {C_CBZ, C_CBNZ})
                  nxt = CBR;
               else
                  nxt = FETCH;
            end
            MEM:     nxt = FETCH;
            CBR:     nxt = FETCH;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
         endcase
      end

      case (nxt)
         FETCH: begin
            ctl_d.add_tri_sel  = 1'b1;
            ctl_d.mem_cs       = 1'b1;
            ctl_d.data_tri_sel = 2'b11;
            ctl_d.ir_load      = 1'b1;
            ctl_d.pc_sel       = 2'b01;
         end
         EXEC, MEM: begin
            if (c inside {C_ADD, C_SUB, C_AND, C_ORR,
                          C_ADDI, C_SUBI, C_ANDI, C_ORRI}) begin
               ctl_d.sa    = rn;
               ctl_d.sb    = rm;
               ctl_d.da    = rd;
               ctl_d.w_reg = 1'b1;
               if (c inside {C_ADDI, C_SUBI, C_ANDI, C_ORRI}) begin
                  ctl_d.b_sel = 1'b1;
                  ctl_d.k     = imm_k;
               end
               if (c inside {C_ADD, C_ADDI}) ctl_d.fs = FS_ADD;
               if (c inside {C_AND, C_ANDI}) ctl_d.fs = FS_AND;
               if (c inside {C_ORR, C_ORRI}) ctl_d.fs = FS_ORR;
               if (c inside {C_SUB, C_SUBI}) begin
                  ctl_d.fs = FS_SUB;
                  ctl_d.c0 = 1'b1;
               end
            end
            if (c inside {C_LDUR, C_STUR}) begin
               ctl_d.sa     = rn;
               ctl_d.b_sel  = 1'b1;
               ctl_d.k      = dt_k;
               ctl_d.fs     = FS_ADD;
               ctl_d.mem_cs = 1'b1;
               if (c == C_STUR) begin
                  ctl_d.sb           = rd;
                  ctl_d.data_tri_sel = 2'b01;
                  ctl_d.mem_write_en = (nxt == MEM);
               end else if (nxt == MEM) begin
                  ctl_d.data_tri_sel = 2'b11;
                  ctl_d.da           = rd;
                  ctl_d.w_reg        = 1'b1;
               end
            end
            if (c == C_B) begin
               ctl_d.pc_sel = 2'b10;
               ctl_d.k      = br_k;
            end
            if (c inside {C_CBZ, C_CBNZ}) begin
               ctl_d.sa          = 5'd31;
               ctl_d.sb          = rd;
               ctl_d.fs          = FS_ORR;
               ctl_d.status_load = 1'b1;
            end
         end
         HALT:    ctl_d.halt = 1'b1;
         default: ctl_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         cls   <= C_BAD;
         run   <= 1'b0;
         ctl_q <= IDLE;
      end else begin
         run   <= 1'b1;
         state <= nxt;
         ctl_q <= ctl_d;
         if (state == DECODE)
            cls <= dec_cls;
      end
   end

   // Z is latched at the end of EXEC, so the branch decision must follow it live.
   assign take = (state == CBR) &&
                 ((cls == C_CBZ  &&  status[0]) ||
                  (cls == C_CBNZ && !status[0]));

   assign add_tri_sel  = ctl_q.add_tri_sel;
   assign data_tri_sel = ctl_q.data_tri_sel;
   assign w_reg        = ctl_q.w_reg;
   assign C0           = ctl_q.c0;
   assign mem_cs       = ctl_q.mem_cs;
   assign mem_write_en = ctl_q.mem_write_en;
   assign IR_load      = ctl_q.ir_load;
   assign status_load  = ctl_q.status_load;
   assign B_Sel        = ctl_q.b_sel;
   assign k            = take ? cb_k : ctl_q.k;
   assign FS           = ctl_q.fs;
   assign size         = 2'b11;
   assign SA           = ctl_q.sa;
   assign SB           = ctl_q.sb;
   assign DA           = ctl_q.da;
   assign PC_sel       = take ? 2'b10 : ctl_q.pc_sel;
   assign halt         = ctl_q.halt;

endmodule
